// File: rtl/crypto_result_buffer_if.sv
// Result-path bundle between the crypto FU / commit logic and the result buffer.
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface crypto_result_buffer_if #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned IdWidth     = 4,
   parameter int unsigned HartIdWidth = 1,
   parameter int unsigned Depth       = 4
);
   localparam int unsigned CntWidth = $clog2(Depth) + 1;

   logic                   alu_valid_i;
   logic [HartIdWidth-1:0] alu_hartid_i;
   logic [IdWidth-1:0]     alu_id_i;
   logic [XLEN-1:0]        alu_data_i;
   logic [4:0]             alu_rd_i;
   logic                   alu_we_i;

   logic                   commit_valid_i;
   logic [IdWidth-1:0]     commit_id_i;
   logic                   commit_kill_i;

   logic                   result_valid_o;
   logic                   result_ready_i;
   logic [HartIdWidth-1:0] result_hartid_o;
   logic [IdWidth-1:0]     result_id_o;
   logic [XLEN-1:0]        result_data_o;
   logic [4:0]             result_rd_o;
   logic                   result_we_o;

   logic                   issue_stall_o;
   logic [CntWidth-1:0]    count_o;
   logic                   overflow_o;

   modport master (
      output alu_valid_i, alu_hartid_i, alu_id_i, alu_data_i, alu_rd_i, alu_we_i,
      output commit_valid_i, commit_id_i, commit_kill_i,
      output result_ready_i,
      input  result_valid_o, result_hartid_o, result_id_o, result_data_o,
      input  result_rd_o, result_we_o,
      input  issue_stall_o, count_o, overflow_o
   );

   modport slave (
      input  alu_valid_i, alu_hartid_i, alu_id_i, alu_data_i, alu_rd_i, alu_we_i,
      input  commit_valid_i, commit_id_i, commit_kill_i,
      input  result_ready_i,
      output result_valid_o, result_hartid_o, result_id_o, result_data_o,
      output result_rd_o, result_we_o,
      output issue_stall_o, count_o, overflow_o
   );
endinterface

// File: rtl/crypto_result_buffer.sv
// In-order result FIFO with commit-kill: push visible one cycle later, all outputs registered-state only.
// Backpressure via result_ready_i; killed heads drain one per cycle; full without pop drops and flags overflow.
module crypto_result_buffer #(
   parameter int unsigned XLEN           = 64,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned HartIdWidth    = 1,
   parameter int unsigned Depth          = 4,
   parameter int unsigned StallThreshold = 1
) (
   input logic                   clk_i,
   input logic                   rst_i,
   crypto_result_buffer_if.slave bus
);
   localparam int unsigned PtrWidth = $clog2(Depth);
   localparam int unsigned CntWidth = PtrWidth + 1;
   localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

   typedef struct packed {
      logic [HartIdWidth-1:0] hartid;
      logic [IdWidth-1:0]     id;
      logic [XLEN-1:0]        data;
      logic [4:0]             rd;
      logic                   we;
   } entry_t;

   entry_t              mem_q [Depth];
   logic [Depth-1:0]    killed_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [CntWidth-1:0] count_q;
   logic                overflow_q;

   entry_t              head;
   entry_t              incoming;
   logic                head_occ;
   logic                head_vld;
   logic                deliver;
   logic                discard;
   logic                pop;
   logic                push;
   logic                drop;
   logic                kill;
   logic                full;
   logic [CntWidth-1:0] free_cnt;
   logic [PtrWidth-1:0] rel [Depth];
   logic [Depth-1:0]    occ;
   logic [Depth-1:0]    kill_hit;

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      incoming        = '0;
      incoming.hartid = bus.alu_hartid_i;
      incoming.id     = bus.alu_id_i;
      incoming.data   = bus.alu_data_i;
      incoming.rd     = bus.alu_rd_i;
      incoming.we     = bus.alu_we_i;
   end

   always_comb begin
      head_occ = (count_q != '0);
      head_vld = head_occ && !killed_q[rd_ptr_q];
      deliver  = head_vld && bus.result_ready_i;
      discard  = head_occ && killed_q[rd_ptr_q];
      pop      = deliver || discard;
      full     = (count_q == DepthCnt);
      push     = bus.alu_valid_i && (!full || pop);
      drop     = bus.alu_valid_i && !push;
      kill     = bus.commit_valid_i && bus.commit_kill_i;
   end

   // Slot i is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      for (int i = 0; i < Depth; i++) begin
         rel[i]      = PtrWidth'(i) - rd_ptr_q;
         occ[i]      = ({1'b0, rel[i]} < count_q);
         kill_hit[i] = kill && occ[i] && (mem_q[i].id == bus.commit_id_i);
      end
   end

   // A delivered head may also be marked killed here; it is popped anyway and
   // the slot's killed bit is rewritten on the next push into it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         killed_q   <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < Depth; i++) begin
            if (kill_hit[i]) begin
               killed_q[i] <= 1'b1;
            end
         end
         if (push) begin
            mem_q[wr_ptr_q]    <= incoming;
            killed_q[wr_ptr_q] <= kill && (bus.alu_id_i == bus.commit_id_i);
            wr_ptr_q           <= wr_ptr_q + PtrWidth'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
         end
         count_q <= count_q + CntWidth'(push) - CntWidth'(pop);
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign free_cnt = DepthCnt - count_q;

   assign bus.result_valid_o  = head_vld;
   assign bus.result_hartid_o = head.hartid;
   assign bus.result_id_o     = head.id;
   assign bus.result_data_o   = head.data;
   assign bus.result_rd_o     = head.rd;
   assign bus.result_we_o     = head.we;
   assign bus.issue_stall_o   = (32'(free_cnt) <= StallThreshold);
   assign bus.count_o         = count_q;
   assign bus.overflow_o      = overflow_q;
endmodule

// File: tb/tb_crypto_result_buffer.sv
// Directed table, reset sequence and randomized traffic for crypto_result_buffer,
// all cross-checked against a queue-based model of the result FIFO.
module tb_crypto_result_buffer;
   localparam int DEPTH = 4;
   localparam int THR   = 1;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   crypto_result_buffer_if #(.XLEN(64), .IdWidth(4), .HartIdWidth(1), .Depth(DEPTH)) bus ();

   crypto_result_buffer #(
      .XLEN(64), .IdWidth(4), .HartIdWidth(1), .Depth(DEPTH), .StallThreshold(THR)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus.slave)
   );

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [3:0]  id;
      logic        hart;
      logic [63:0] data;
      logic [4:0]  rd;
      logic        we;
      bit          killed;
   } ment_t;

   ment_t mq[$];
   bit    m_ovf = 1'b0;

   typedef struct {
      bit v; bit [3:0] id; bit rdy; bit cv; bit ck; bit [3:0] cid;
      bit ev; bit [3:0] eid; int ecnt; bit estall; bit eovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit v, bit [3:0] id, bit rdy, bit cv, bit ck, bit [3:0] cid,
                               bit ev, bit [3:0] eid, int ecnt, bit estall, bit eovf);
      vec_t r;
      r.v = v; r.id = id; r.rdy = rdy; r.cv = cv; r.ck = ck; r.cid = cid;
      r.ev = ev; r.eid = eid; r.ecnt = ecnt; r.estall = estall; r.eovf = eovf;
      return r;
   endfunction

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic drive(bit v, bit [3:0] id, bit rdy, bit cv, bit ck, bit [3:0] cid);
      logic [3:0] idv;
      idv = id;
      bus.alu_valid_i    = v;
      bus.alu_id_i       = idv;
      bus.alu_hartid_i   = idv[0];
      bus.alu_data_i     = 64'hC0DE_0000_0000_0000 | {60'd0, idv};
      bus.alu_rd_i       = 5'(idv) + 5'd5;
      bus.alu_we_i       = idv[1];
      bus.result_ready_i = rdy;
      bus.commit_valid_i = cv;
      bus.commit_kill_i  = ck;
      bus.commit_id_i    = cid;
   endtask

   task automatic compare_model();
      bit exp_vld;
      exp_vld = (mq.size() > 0) && !mq[0].killed;
      chk("valid", bus.result_valid_o, exp_vld);
      chk("count", bus.count_o, mq.size());
      chk("stall", bus.issue_stall_o, (DEPTH - mq.size()) <= THR);
      chk("overflow", bus.overflow_o, m_ovf);
      if (exp_vld) begin
         chk("id", bus.result_id_o, mq[0].id);
         chk("data", bus.result_data_o, mq[0].data);
         chk("hartid", bus.result_hartid_o, mq[0].hart);
         chk("rd", bus.result_rd_o, mq[0].rd);
         chk("we", bus.result_we_o, mq[0].we);
      end
   endtask

   // Advance the model by one edge from the inputs currently driven, clock the DUT, compare.
   task automatic do_cycle();
      bit    vld, deliver, discard, pop, push;
      ment_t e;
      if (rst_i) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         vld     = (mq.size() > 0) && !mq[0].killed;
         deliver = vld && bus.result_ready_i;
         discard = (mq.size() > 0) && mq[0].killed;
         pop     = deliver || discard;
         push    = bus.alu_valid_i && ((mq.size() < DEPTH) || pop);
         if (bus.alu_valid_i && !push) m_ovf = 1'b1;
         if (bus.commit_valid_i && bus.commit_kill_i)
            foreach (mq[i]) if (mq[i].id == bus.commit_id_i) mq[i].killed = 1'b1;
         if (pop) void'(mq.pop_front());
         if (push) begin
            e.id     = bus.alu_id_i;
            e.hart   = bus.alu_hartid_i;
            e.data   = bus.alu_data_i;
            e.rd     = bus.alu_rd_i;
            e.we     = bus.alu_we_i;
            e.killed = bus.commit_valid_i && bus.commit_kill_i && (bus.alu_id_i == bus.commit_id_i);
            mq.push_back(e);
         end
      end
      @(posedge clk_i);
      #1;
      compare_model();
   endtask

   initial begin
      // back-to-back
      tbl.push_back(mk(1,1,1,0,0,0, 1,1,1,0,0));
      tbl.push_back(mk(1,2,1,0,0,0, 1,2,1,0,0));
      tbl.push_back(mk(1,3,1,0,0,0, 1,3,1,0,0));
      tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0));
      // backpressure to full, fifth push dropped
      tbl.push_back(mk(1,1,0,0,0,0, 1,1,1,0,0));
      tbl.push_back(mk(1,2,0,0,0,0, 1,1,2,0,0));
      tbl.push_back(mk(1,3,0,0,0,0, 1,1,3,1,0));
      tbl.push_back(mk(1,4,0,0,0,0, 1,1,4,1,0));
      tbl.push_back(mk(1,5,0,0,0,0, 1,1,4,1,1));
      tbl.push_back(mk(0,0,0,0,0,0, 1,1,4,1,1));
      // full push+pop, then drain
      tbl.push_back(mk(1,7,1,0,0,0, 1,2,4,1,1));
      tbl.push_back(mk(0,0,1,0,0,0, 1,3,3,1,1));
      tbl.push_back(mk(0,0,1,0,0,0, 1,4,2,0,1));
      tbl.push_back(mk(0,0,1,0,0,0, 1,7,1,0,1));
      tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,1));
      // kill of a queued middle entry
      tbl.push_back(mk(1,4,0,0,0,0, 1,4,1,0,1));
      tbl.push_back(mk(1,5,0,0,0,0, 1,4,2,0,1));
      tbl.push_back(mk(1,6,0,0,0,0, 1,4,3,1,1));
      tbl.push_back(mk(0,0,0,1,1,5, 1,4,3,1,1));
      tbl.push_back(mk(0,0,1,0,0,0, 0,0,2,0,1));
      tbl.push_back(mk(0,0,1,0,0,0, 1,6,1,0,1));
      tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,1));
      // kill vs. handshake on the head
      tbl.push_back(mk(1,2,0,0,0,0, 1,2,1,0,1));
      tbl.push_back(mk(1,3,0,0,0,0, 1,2,2,0,1));
      tbl.push_back(mk(0,0,1,1,1,2, 1,3,1,0,1));
      tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,1));
      // commit without kill, then kill of an entry pushed in the same cycle
      tbl.push_back(mk(1,9,0,0,0,0, 1,9,1,0,1));
      tbl.push_back(mk(0,0,0,1,0,9, 1,9,1,0,1));
      tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,1));
      tbl.push_back(mk(1,10,0,1,1,10, 0,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));

      drive(0,0,0,0,0,0);
      rst_i = 1'b1;
      do_cycle();
      do_cycle();
      chk("rst_valid", bus.result_valid_o, 0);
      chk("rst_count", bus.count_o, 0);
      chk("rst_stall", bus.issue_stall_o, 0);
      chk("rst_overflow", bus.overflow_o, 0);
      chk("rst_data", bus.result_data_o, 0);
      chk("rst_id", bus.result_id_o, 0);
      rst_i = 1'b0;

      foreach (tbl[k]) begin
         drive(tbl[k].v, tbl[k].id, tbl[k].rdy, tbl[k].cv, tbl[k].ck, tbl[k].cid);
         do_cycle();
         chk($sformatf("tbl%0d_valid", k), bus.result_valid_o, tbl[k].ev);
         chk($sformatf("tbl%0d_count", k), bus.count_o, tbl[k].ecnt);
         chk($sformatf("tbl%0d_stall", k), bus.issue_stall_o, tbl[k].estall);
         chk($sformatf("tbl%0d_overflow", k), bus.overflow_o, tbl[k].eovf);
         if (tbl[k].ev) chk($sformatf("tbl%0d_id", k), bus.result_id_o, tbl[k].eid);
      end

      // reset in the middle of operation with overflow set
      for (int i = 1; i <= 3; i++) begin
         drive(1, 4'(i), 0, 0, 0, 0);
         do_cycle();
      end
      chk("pre_rst_count", bus.count_o, 3);
      drive(1, 4'd12, 1, 1, 1, 4'd1);
      rst_i = 1'b1;
      do_cycle();
      rst_i = 1'b0;
      chk("mid_rst_count", bus.count_o, 0);
      chk("mid_rst_valid", bus.result_valid_o, 0);
      chk("mid_rst_overflow", bus.overflow_o, 0);
      drive(1, 4'd11, 0, 0, 0, 0);
      do_cycle();
      chk("post_rst_valid", bus.result_valid_o, 1);
      chk("post_rst_id", bus.result_id_o, 11);
      chk("post_rst_count", bus.count_o, 1);
      drive(0, 0, 1, 0, 0, 0);
      do_cycle();
      chk("post_rst_drain", bus.count_o, 0);

      // randomized traffic with shifting ready pressure
      for (int c = 0; c < 4000; c++) begin
         int rdy_pct;
         rdy_pct = ((c / 250) % 4) * 30 + 5;
         bus.alu_valid_i    = ($urandom_range(0, 2) != 0);
         bus.alu_id_i       = 4'($urandom_range(0, 7));
         bus.alu_hartid_i   = 1'($urandom);
         bus.alu_data_i     = {$urandom, $urandom};
         bus.alu_rd_i       = 5'($urandom);
         bus.alu_we_i       = 1'($urandom);
         bus.result_ready_i = ($urandom_range(0, 99) < rdy_pct);
         bus.commit_valid_i = ($urandom_range(0, 1) != 0);
         bus.commit_kill_i  = ($urandom_range(0, 3) == 0);
         bus.commit_id_i    = 4'($urandom_range(0, 7));
         rst_i              = ($urandom_range(0, 499) == 0);
         do_cycle();
      end
      rst_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
